alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Instruction issue and writeback controller that drives the two-operand, 2-bit-opcode ALU (ops: 00 XNOR, 01 ADD, 10 AND, 11 SUB; zero flag returned). It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8×32 register file. It issues them to the ALU, captures result and zero flag, writes back the destination register and presents a completion record over a second valid/ready handshake. It sits between the fetch/sequencing logic and the ALU datapath.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  controller can accept an instruction
- in_instr  in  32  [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [15:0] imm
- alu_a  out  DATA_W  ALU operand A (registered)
- alu_b  out  DATA_W  ALU operand B (registered)
- alu_op  out  2  ALU operation select (registered)
- alu_result  in  DATA_W  ALU combinational result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  completion record valid
- out_ready  in  1  consumer accepts record
- out_result  out  DATA_W  captured result
- out_zero  out  1  captured zero flag
- out_rd  out  3  destination register of completed instruction
- out_illegal  out  1  completed instruction had an undefined opcode

## Operation
- Opcodes: 0 XNOR, 1 ADD, 2 AND, 3 SUB (rd ← rs1 op rs2; alu_op = opcode[1:0]); 4 CMP (SUB, no writeback); 5 LDI (alu_op=01, a=0, b=zero-extended imm, rd ← imm); 6–15 illegal.
- Register file: 8 × DATA_W, cleared on reset; r0 reads 0; writes to r0 discarded.
- FSM: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready: register alu_a, alu_b, alu_op and the decoded rd/write-enable/illegal flag; go to EXEC.
  - EXEC: in_ready=0. Capture alu_result→out_result and alu_zero→out_zero. Write rd if write-enabled and rd≠0. Set out_valid; go to DONE.
  - DONE: hold all out_* stable while out_valid & !out_ready. On out_ready, clear out_valid and go to IDLE.
- Illegal opcode: alu_op=01, a=b=0; no writeback. Record: out_result=0, out_zero=0, out_illegal=1, out_rd=instr rd.
- Arithmetic wraps modulo 2^DATA_W; no carry/overflow reported.
- Operands are read in IDLE, after the previous writeback in EXEC, so no hazard logic is required.
- in_instr bits [18:16] are ignored.

## Timing
- Reset values: in_ready=1, alu_a=0, alu_b=0, alu_op=2'b00, out_valid=0, out_result=0, out_zero=0, out_rd=0, out_illegal=0, FSM=IDLE, register file all 0.
- Accept at edge N; ALU inputs valid after N; out_valid high after N+1.
- Minimum issue interval is 3 cycles (accept, EXEC, DONE with out_ready=1); next accept at N+3.
- in_ready is combinational from state only and never depends on in_valid.
- Reset asserted in any state returns to IDLE immediately; any in-flight instruction is dropped without writeback.
- out_* are registered; ALU outputs are sampled only in EXEC.

## Configuration
- ALU_ISSUE_RETIRE_CNT_EN defined: adds output retire_cnt (16 bits). It increments on every out_valid&out_ready handshake, including illegal ones, wraps 0xFFFF→0 and resets to 0.
- Not defined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- LDI r1,5; LDI r2,5; SUB r3,r1,r2 → third record out_result=0, out_zero=1, out_rd=3; subsequent ADD r4,r3,r1 gives 5.
- XNOR r5,r0,r0 → 0xFFFFFFFF; LDI r6,1; ADD r7,r5,r6 → out_result=0, out_zero=1 (wrap).
- LDI r0,0x1234, then ADD r1,r0,r0 → out_result=0; r0 is unchanged.
- CMP r1,r2 with r1=7, r2=3 → out_result=4, out_zero=0; a later ADD r3,r3,r0 shows r3 was not modified.
- Hold out_ready=0 for 5 cycles after out_valid → out_* are stable, in_ready=0, and an in_valid pulse is not accepted; accept occurs one cycle after release.
- Opcode 0xA → out_illegal=1, out_result=0, no register changed. Assert rst_n low during EXEC of ADD r1 → r1=0, out_valid=0, in_ready=1 after reset.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue ALU controller with 8x32 register file and writeback; optional ALU_ISSUE_RETIRE_CNT_EN retire counter
module alu_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [2:0]        out_rd,
    output logic              out_illegal
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    ,
    output logic [15:0]       retire_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [8];
    logic [2:0]        pend_rd;
    logic              pend_we;
    logic              pend_ill;

    logic [3:0]        opcode;
    logic [2:0]        dec_rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [1:0]        dec_op;
    logic              dec_we;
    logic              dec_ill;
    logic              unused_bits;

    assign opcode      = in_instr[31:28];
    assign dec_rd      = in_instr[27:25];
    assign rs1         = in_instr[24:22];
    assign rs2         = in_instr[21:19];
    assign imm         = in_instr[15:0];
    assign unused_bits = ^in_instr[18:16];

    // r0 is hardwired to zero on the read side as well as never written
    assign rs1_val = (rs1 == 3'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 3'd0) ? '0 : rf[rs2];

    assign in_ready = (state == IDLE);

    // Decode the incoming instruction into ALU operands and writeback intent
    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_op  = 2'b01;
        dec_we  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                dec_a  = rs1_val;
                dec_b  = rs2_val;
                dec_op = opcode[1:0];
                dec_we = 1'b1;
            end
            4'd4: begin
                dec_a  = rs1_val;
                dec_b  = rs2_val;
                dec_op = 2'b11;
            end
            4'd5: begin
                dec_b  = {{(DATA_W-16){1'b0}}, imm};
                dec_we = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Issue/execute/complete sequencing, register file writeback and output records
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 2'b00;
            pend_rd     <= 3'd0;
            pend_we     <= 1'b0;
            pend_ill    <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_rd      <= 3'd0;
            out_illegal <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a    <= dec_a;
                        alu_b    <= dec_b;
                        alu_op   <= dec_op;
                        pend_rd  <= dec_rd;
                        pend_we  <= dec_we;
                        pend_ill <= dec_ill;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal instructions report a clean zero record regardless of the ALU
                    out_result  <= pend_ill ? '0 : alu_result;
                    out_zero    <= pend_ill ? 1'b0 : alu_zero;
                    out_rd      <= pend_rd;
                    out_illegal <= pend_ill;
                    out_valid   <= 1'b1;
                    if (pend_we && !pend_ill && (pend_rd != 3'd0)) begin
                        rf[pend_rd] <= alu_result;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    // Count completed records, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule
